// File: rtl/fb_wr_arbiter_pkg.sv
// Shared definitions for the frame-buffer write path: display modes, FIFO entry
// sizing and the pixel-to-address mapping also used by the display readout.
package fb_wr_arbiter_pkg;

   typedef enum logic [1:0] {
      MODE_CAM1  = 2'd0,
      MODE_CAM2  = 2'd1,
      MODE_SPLIT = 2'd2,
      MODE_RSVD  = 2'd3
   } fb_mode_e;

   localparam int FB_DEF_ADDR_WIDTH = 17;
   localparam int FB_DEF_DATA_WIDTH = 12;

   function automatic int fb_entry_width(input int addrWidth, input int dataWidth);
      return addrWidth + dataWidth;
   endfunction

   localparam int FB_ENTRY_WIDTH = fb_entry_width(FB_DEF_ADDR_WIDTH, FB_DEF_DATA_WIDTH);

   // Split mode squeezes each camera into half a line by dropping every other pixel.
   function automatic logic [31:0] fb_map_addr(input logic [31:0] line,
                                               input logic [31:0] pixel,
                                               input logic [31:0] fbWidth,
                                               input logic        split,
                                               input logic        rightHalf);
      logic [31:0] col;
      col = pixel;
      if (split) begin
         col = (pixel >> 1) + (rightHalf ? (fbWidth >> 1) : 32'd0);
      end
      return line * fbWidth + col;
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering one camera's {addr, data} writes.
// A push into a full FIFO is accepted only when the same cycle pops.
module fb_wr_fifo #(
   parameter int WIDTH = 29,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush, doPop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = mem_q[rdPtr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      unique case ({doPush, doPop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/fb_wr_arbiter.sv
// Merges the two camera pixel streams onto the single frame-buffer write port
// through per-camera FIFOs and a round-robin arbiter with sticky overflow flags.
module fb_wr_arbiter
   import fb_wr_arbiter_pkg::*;
#(
   parameter int CAM_DATA_WIDTH = 12,
   parameter int CAM_LINE       = 9,
   parameter int CAM_PIXEL      = 10,
   parameter int ADDR_WIDTH     = 17,
   parameter int FB_WIDTH       = 320,
   parameter int FB_DEPTH       = 240,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_enable,
   input  logic [1:0]                i_mode,
   input  logic                      i_clr,
   input  logic                      i_we_cam1,
   input  logic                      i_we_cam2,
   input  logic [CAM_DATA_WIDTH-1:0] i_data_cam1,
   input  logic [CAM_DATA_WIDTH-1:0] i_data_cam2,
   input  logic [CAM_LINE-1:0]       i_line_cam1,
   input  logic [CAM_LINE-1:0]       i_line_cam2,
   input  logic [CAM_PIXEL-1:0]      i_pixel_cam1,
   input  logic [CAM_PIXEL-1:0]      i_pixel_cam2,
   output logic                      o_we,
   output logic [ADDR_WIDTH-1:0]     o_addr_wr,
   output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
   output logic [1:0]                o_grant,
   output logic                      o_ovf_cam1,
   output logic                      o_ovf_cam2
);

   localparam int ENTRY_W = fb_entry_width(ADDR_WIDTH, CAM_DATA_WIDTH);

   logic                      split, sel1, sel2, inWin1, inWin2, push1, push2;
   logic [ADDR_WIDTH-1:0]     pushAddr1, pushAddr2;
   logic [ENTRY_W-1:0]        entry1, entry2;
   logic                      full1, full2, empty1, empty2;
   logic                      grant1, grant2;
   logic                      rr_q, rr_d;
   logic                      ovf1_q, ovf1_d, ovf2_q, ovf2_d;
   logic                      we_q, we_d;
   logic [1:0]                grant_q, grant_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [CAM_DATA_WIDTH-1:0] data_q, data_d;

   // The reserved mode behaves as split.
   assign split  = (i_mode == MODE_SPLIT) || (i_mode == MODE_RSVD);
   assign sel1   = (i_mode == MODE_CAM1) || split;
   assign sel2   = (i_mode == MODE_CAM2) || split;
   assign inWin1 = (32'(i_line_cam1) < 32'(FB_DEPTH)) && (32'(i_pixel_cam1) < 32'(FB_WIDTH));
   assign inWin2 = (32'(i_line_cam2) < 32'(FB_DEPTH)) && (32'(i_pixel_cam2) < 32'(FB_WIDTH));
   assign push1  = i_we_cam1 && i_enable && sel1 && inWin1;
   assign push2  = i_we_cam2 && i_enable && sel2 && inWin2;

   assign pushAddr1 = ADDR_WIDTH'(fb_map_addr(32'(i_line_cam1), 32'(i_pixel_cam1),
                                              32'(FB_WIDTH), split, 1'b0));
   assign pushAddr2 = ADDR_WIDTH'(fb_map_addr(32'(i_line_cam2), 32'(i_pixel_cam2),
                                              32'(FB_WIDTH), split, 1'b1));

   fb_wr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) fifoCam1 (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push1),
      .pop_i   (grant1),
      .data_i  ({pushAddr1, i_data_cam1}),
      .data_o  (entry1),
      .full_o  (full1),
      .empty_o (empty1)
   );

   fb_wr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) fifoCam2 (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push2),
      .pop_i   (grant2),
      .data_i  ({pushAddr2, i_data_cam2}),
      .data_o  (entry2),
      .full_o  (full2),
      .empty_o (empty2)
   );

   // rr_q = 1 means cam2 is preferred on the next contention.
   always_comb begin
      grant1  = !empty1 && (empty2 || !rr_q);
      grant2  = !empty2 && !grant1;
      rr_d    = rr_q;
      we_d    = grant1 || grant2;
      grant_d = {grant2, grant1};
      addr_d  = addr_q;
      data_d  = data_q;
      if (grant1) begin
         rr_d   = 1'b1;
         addr_d = entry1[ENTRY_W-1 -: ADDR_WIDTH];
         data_d = entry1[CAM_DATA_WIDTH-1:0];
      end else if (grant2) begin
         rr_d   = 1'b0;
         addr_d = entry2[ENTRY_W-1 -: ADDR_WIDTH];
         data_d = entry2[CAM_DATA_WIDTH-1:0];
      end
      ovf1_d = ovf1_q;
      ovf2_d = ovf2_q;
      if (i_clr) begin
         ovf1_d = 1'b0;
         ovf2_d = 1'b0;
      end
      if (push1 && full1 && !grant1) begin
         ovf1_d = 1'b1;
      end
      if (push2 && full2 && !grant2) begin
         ovf2_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q    <= 1'b0;
         ovf1_q  <= 1'b0;
         ovf2_q  <= 1'b0;
         we_q    <= 1'b0;
         grant_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         rr_q    <= rr_d;
         ovf1_q  <= ovf1_d;
         ovf2_q  <= ovf2_d;
         we_q    <= we_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign o_we       = we_q;
   assign o_grant    = grant_q;
   assign o_addr_wr  = addr_q;
   assign o_data_wr  = data_q;
   assign o_ovf_cam1 = ovf1_q;
   assign o_ovf_cam2 = ovf2_q;

endmodule

// File: doc/fb_wr_arbiter.md
# fb_wr_arbiter

Shares the single frame-buffer write port between the two camera pixel streams that leave the per-camera gray/transform stages. Each camera's writes are address-mapped per display mode and buffered in a small per-camera FIFO. A round-robin arbiter then issues at most one frame-buffer write per `clk`. Overflowing pixels are dropped and flagged, so the two cameras never corrupt each other's writes.

## Interface
Parameters:
- `CAM_DATA_WIDTH`, 12, pixel data width
- `CAM_LINE`, 9, line index width
- `CAM_PIXEL`, 10, pixel index width
- `ADDR_WIDTH`, 17, frame-buffer address width
- `FB_WIDTH`, 320, frame-buffer pixels per line
- `FB_DEPTH`, 240, frame-buffer lines
- `FIFO_DEPTH`, 4, entries per camera FIFO (power of 2)

Ports:
- `clk`, in, 1, single clock for the whole block
- `reset`, in, 1, asynchronous, active-high
- `i_enable`, in, 1, accept new pixels when high
- `i_mode`, in, 2, 0 = cam1 full frame, 1 = cam2 full frame, 2 = split (cam1 left half, cam2 right half), 3 = reserved (treated as 2)
- `i_clr`, in, 1, clears the sticky overflow flags
- `i_we_cam1` / `i_we_cam2`, in, 1, pixel valid
- `i_data_cam1` / `i_data_cam2`, in, `CAM_DATA_WIDTH`, pixel value
- `i_line_cam1` / `i_line_cam2`, in, `CAM_LINE`, line index
- `i_pixel_cam1` / `i_pixel_cam2`, in, `CAM_PIXEL`, pixel index
- `o_we`, out, 1, frame-buffer write strobe
- `o_addr_wr`, out, `ADDR_WIDTH`, write address
- `o_data_wr`, out, `CAM_DATA_WIDTH`, write data
- `o_grant`, out, 2, one-hot source of the current `o_we` (bit 0 = cam1); 0 when idle
- `o_ovf_cam1` / `o_ovf_cam2`, out, 1, sticky overflow flag per camera

## Operation
- **Push filter.** A camera pushes only when `i_we` = 1, `i_enable` = 1, the camera is selected by `i_mode`, line < `FB_DEPTH`, and pixel < `FB_WIDTH`. Otherwise the pixel is ignored silently; ignored pixels do not set overflow.
- **Address in full mode.** addr = line·`FB_WIDTH` + pixel. The product is computed at `ADDR_WIDTH` and is never truncated, because 239·320 + 319 = 76799 < 2^17.
- **Address in split mode.**
  - cam1: addr = line·`FB_WIDTH` + (pixel >> 1)
  - cam2: addr = line·`FB_WIDTH` + `FB_WIDTH`/2 + (pixel >> 1)
- **What the FIFO stores.** The address is computed at push time and stored with the data as {addr, data}. A mode change therefore never remaps pixels that are already buffered.
- **FIFO full.** A push is accepted if the FIFO is not full, or if the same FIFO is popped in that cycle. Otherwise the pixel is dropped and that camera's `o_ovf` is set.
- **Overflow clear.** `i_clr` clears both flags. If `i_clr` and a new overflow occur in the same cycle, set wins.
- **Arbiter.**
  - Each cycle, pop at most one non-empty FIFO.
  - If both are non-empty, grant the camera that was not granted last. Track this in a 1-bit rr register (reset = cam1 preferred) that updates only on a grant.
  - If only one FIFO is non-empty, grant it regardless of rr.
- **`i_enable` low.** Pushes stop; the FIFOs still drain to the frame buffer.
- **Reset mid-operation.** All FIFO contents are discarded, pointers and counts go to 0, and rr returns to cam1.

## Timing
- Reset values:
  - `o_we` = 0, `o_addr_wr` = 0, `o_data_wr` = 0, `o_grant` = 0
  - `o_ovf_cam1` = 0, `o_ovf_cam2` = 0
  - FIFOs empty
- Outputs are registered. A push at cycle N into an empty, uncontested FIFO is popped at N+1 and appears on `o_we`/`o_addr_wr`/`o_data_wr` at N+2. Latency is 2 cycles.
- `o_we` is high for exactly one cycle per popped entry.
- `o_addr_wr`, `o_data_wr` and `o_grant` are valid while `o_we` = 1; the address and data hold their last value otherwise.
- Sustained throughput is one write per cycle total. With both cameras pushing every cycle, each camera receives a grant every 2nd cycle, so both FIFOs fill and overflow. The cameras' normal pixel rate is ≤ 1 pixel per 2 `clk` each, which is sustainable.
- A push and a pop on the same FIFO in the same cycle leave the count unchanged.

## Structure
- **Shared package:** mode constants (`MODE_CAM1`, `MODE_CAM2`, `MODE_SPLIT`), the FIFO entry width (`ADDR_WIDTH` + `CAM_DATA_WIDTH`), and the address-mapping function shared with the display readout.
- **Sub-module `fb_wr_fifo`:** a parameterised synchronous FIFO with async active-high `reset`, push/pop, full/empty and count. It is instantiated twice.
- **Top level:** contains the push filter, address mapping, arbiter, output registers and overflow flags.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-burst → outputs go to 0 immediately and the FIFOs are empty; after release, the first write comes from a fresh push.
- **Mode 0, single pixel.** Push cam1 at line = 2, pixel = 5, data = 0xABC at cycle N → `o_we` at N+2 with addr = 645, data = 0xABC, `o_grant` = 01. A simultaneous cam2 push is ignored and its flag stays 0.
- **Mode 2, contention.** Push cam1 (line 0, pixel 10) and cam2 (line 0, pixel 10) in the same cycle → two consecutive writes: addr 5 with grant 01, then addr 165 with grant 10. rr then prefers cam1 on the next contention.
- **Overflow.** Mode 2, both cameras push every cycle for 12 cycles → both `o_ovf` flags set. Every written address is unique and in order per camera. `i_clr` clears both flags.
- **Window.** Push line = 240 or pixel = 320 → no write and no overflow.
- **Mode change and enable.** Switch mode 0 → 1 while cam1 entries are buffered → those entries still write to their cam1 addresses. `i_enable` = 0 blocks new pushes, but the buffered entries still drain.
